// File: rtl/dsp_fetch.sv
// dsp_fetch: instruction fetch stage with a one-entry skid buffer and redirect flush
//
// Fetches sequential instruction words from a request/ack memory and presents
// them to decode one per cycle. A word that arrives while decode is stalled is
// parked in a skid register so no fetch is lost. A redirect flushes everything
// and restarts at the new target; a request already in flight is allowed to
// complete and its word is dropped.
//
// Parameters:
//   ADDR_W   instruction word-address width
//   INST_W   instruction word width
//   RESET_PC first fetch address after reset
//
// Ports:
//   clk            clock, all state updates on its rising edge
//   rst_n          asynchronous active-low reset
//   imem_req       memory read request (held until acked)
//   imem_addr      word address of the request
//   imem_ack       memory response strobe, qualifies imem_rdata
//   imem_rdata     returned instruction word
//   stall          decode hold, output is not consumed while high
//   redirect_valid one-cycle branch/jump redirect strobe
//   redirect_addr  redirect target
//   inst_valid     qualifies inst_out / inst_pc
//   inst_out       instruction presented to decode
//   inst_pc        address of inst_out
//   stall_cnt      saturating count of stalled-valid cycles
//                  (present only when DSP_FETCH_PERF_EN is defined)
//
// Optional feature macro: DSP_FETCH_PERF_EN
`ifndef MEM_ADDR_LEN
`define MEM_ADDR_LEN 32
`endif
`ifndef INST_WORD_LEN
`define INST_WORD_LEN 32
`endif
module dsp_fetch #(
   parameter int                ADDR_W   = `MEM_ADDR_LEN,
   parameter int                INST_W   = `INST_WORD_LEN,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst_out,
   output logic [ADDR_W-1:0] inst_pc
`ifdef DSP_FETCH_PERF_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;
   // The skid register is full exactly while the FSM is in HOLD.
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              req_q, req_d;
   logic              valid_q, valid_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic [INST_W-1:0] skid_inst_q, skid_inst_d;
   logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
   logic              consume;
   logic [ADDR_W-1:0] pc_inc;
   assign consume = valid_q & ~stall;
   assign pc_inc  = pc_q + ADDR_W'(1);
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      req_d       = req_q;
      valid_d     = valid_q;
      inst_d      = inst_q;
      ipc_d       = ipc_q;
      skid_inst_d = skid_inst_q;
      skid_pc_d   = skid_pc_q;
      if (redirect_valid) begin
         pc_d    = redirect_addr;
         valid_d = 1'b0;
         // An in-flight request must still complete at its old address;
         // FLUSH waits for it and drops the word. Otherwise restart now.
         if (req_q && !imem_ack) begin
            state_d = FLUSH;
         end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = redirect_addr;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = REQ;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end
            REQ: begin
               if (imem_ack) begin
                  pc_d   = pc_inc;
                  addr_d = pc_inc;
                  if (!valid_q || consume) begin
                     inst_d  = imem_rdata;
                     ipc_d   = pc_q;
                     valid_d = 1'b1;
                  end else begin
                     skid_inst_d = imem_rdata;
                     skid_pc_d   = pc_q;
                     state_d     = HOLD;
                     req_d       = 1'b0;
                  end
               end else if (consume) begin
                  valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (consume) begin
                  inst_d  = skid_inst_q;
                  ipc_d   = skid_pc_q;
                  valid_d = 1'b1;
                  state_d = REQ;
                  req_d   = 1'b1;
                  addr_d  = pc_q;
               end
            end
            FLUSH: begin
               if (imem_ack) begin
                  state_d = REQ;
                  addr_d  = pc_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         req_q       <= 1'b0;
         valid_q     <= 1'b0;
         inst_q      <= '0;
         ipc_q       <= '0;
         skid_inst_q <= '0;
         skid_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         req_q       <= req_d;
         valid_q     <= valid_d;
         inst_q      <= inst_d;
         ipc_q       <= ipc_d;
         skid_inst_q <= skid_inst_d;
         skid_pc_q   <= skid_pc_d;
      end
   end
   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign inst_valid = valid_q;
   assign inst_out   = inst_q;
   assign inst_pc    = ipc_q;
`ifdef DSP_FETCH_PERF_EN
   logic [15:0] stall_cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else if (valid_q && stall && stall_cnt_q != 16'hFFFF)
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end
   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_dsp_fetch.sv
// tb_dsp_fetch: directed bench for dsp_fetch with a queue-level reference model
`timescale 1ns/1ps
module tb_dsp_fetch;
   localparam int AW = 16;
   localparam int IW = 32;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          imem_req, imem_ack, inst_valid;
   logic          stall = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_addr = '0;
   logic [AW-1:0] imem_addr, inst_pc;
   logic [IW-1:0] imem_rdata, inst_out;
`ifdef DSP_FETCH_PERF_EN
   logic [15:0]   stall_cnt;
`endif
   int lat = 0;
   int wcnt;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dsp_fetch #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc)
`ifdef DSP_FETCH_PERF_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   // Memory: word content equals its address; ack after 'lat' waiting cycles.
   assign imem_rdata = {16'h0000, imem_addr};
   assign imem_ack   = imem_req && (wcnt >= lat);
   always @(posedge clk or negedge rst_n)
      if (!rst_n) wcnt <= 0;
      else wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: fetched words in program order in a queue of depth 2
   // (output + skid). A request is wanted whenever started and not full.
   bit            m_run = 0, m_flush = 0, mr;
   int            m_n = 0;
   logic [AW-1:0] m_pc = '0, m_old = '0;
   logic [IW-1:0] m_w[2];
   logic [AW-1:0] m_p[2];
   function automatic bit m_req();
      return m_run && m_n < 2;
   endfunction
   function automatic logic [AW-1:0] m_addr();
      return m_flush ? m_old : m_pc;
   endfunction
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_run = 0; m_flush = 0; m_n = 0; m_pc = '0;
      end else if (!m_run) begin
         m_run = 1;
         if (redirect_valid) m_pc = redirect_addr;
      end else begin
         mr = m_req();
         if (redirect_valid) begin
            m_n = 0;
            if (mr && !imem_ack) begin
               m_old = m_addr();
               m_flush = 1;
            end else m_flush = 0;
            m_pc = redirect_addr;
         end else begin
            if (m_n > 0 && !stall) begin
               m_w[0] = m_w[1]; m_p[0] = m_p[1]; m_n--;
            end
            if (mr && imem_ack) begin
               if (m_flush) m_flush = 0;
               else begin
                  m_w[m_n] = imem_rdata; m_p[m_n] = m_pc; m_n++; m_pc = m_pc + 1'b1;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("m_valid", inst_valid, m_n > 0);
         if (m_n > 0) begin
            chk("m_inst_pc", inst_pc, m_p[0]);
            chk("m_inst_out", inst_out, m_w[0]);
         end
         chk("m_req", imem_req, m_req());
         if (m_req()) chk("m_addr", imem_addr, m_addr());
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_out", inst_out, 0);
      chk("rst_pc", inst_pc, 0);
`ifdef DSP_FETCH_PERF_EN
      chk("rst_cnt", stall_cnt, 0);
`endif
      @(negedge clk); rst_n = 1'b1;
      // Streaming with zero-latency ack
      @(negedge clk);
      chk("s_req", imem_req, 1);
      chk("s_addr0", imem_addr, 0);
      chk("s_valid0", inst_valid, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("s_valid", inst_valid, 1);
         chk("s_pc", inst_pc, i);
         chk("s_out", inst_out, i);
         chk("s_addr", imem_addr, i + 1);
      end
      // Stall three cycles while pc 5 is presented
      stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("k_pc5", inst_pc, 5);
         chk("k_req0", imem_req, 0);
      end
      stall = 1'b0;
      @(negedge clk); chk("k_pc6", inst_pc, 6); chk("k_v6", inst_valid, 1);
      @(negedge clk); chk("k_pc7", inst_pc, 7);
      // Delayed ack, redirect in cycle 2, replaced while flushing
      lat = 4;
      @(negedge clk);
      @(negedge clk);
      redirect_valid = 1'b1; redirect_addr = 16'h0030;
      @(negedge clk);
      redirect_addr = 16'h0040;
      chk("f_addr_old", imem_addr, 8);
      chk("f_valid0", inst_valid, 0);
      @(negedge clk);
      redirect_valid = 1'b0;
      n = 0;
      while (imem_addr !== 16'h0040 && n < 10) begin
         chk("f_hold", imem_addr, 8);
         @(negedge clk);
         n++;
      end
      chk("f_addr40", imem_addr, 16'h0040);
      chk("f_nv", inst_valid, 0);
      lat = 0;
      @(negedge clk);
      chk("f_pc40", inst_pc, 16'h0040);
      chk("f_out40", inst_out, 32'h40);
      chk("f_v40", inst_valid, 1);
      // Redirect coinciding with an ack
      redirect_valid = 1'b1; redirect_addr = 16'h0080;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("ra_valid0", inst_valid, 0);
      chk("ra_addr", imem_addr, 16'h0080);
      @(negedge clk);
      chk("ra_pc80", inst_pc, 16'h0080);
      // Redirect while stalled with the skid full
      stall = 1'b1;
      @(negedge clk); chk("rs_req0", imem_req, 0);
      @(negedge clk);
      redirect_valid = 1'b1; redirect_addr = 16'h0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rs_valid0", inst_valid, 0);
      chk("rs_addr", imem_addr, 16'h0100);
      stall = 1'b0;
      @(negedge clk);
      chk("rs_pc100", inst_pc, 16'h0100);
      chk("rs_out100", inst_out, 32'h100);
      // Address wrap, then asynchronous reset in HOLD
      redirect_valid = 1'b1; redirect_addr = 16'hFFFF;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("w_addr", imem_addr, 16'hFFFF);
      @(negedge clk);
      chk("w_pc", inst_pc, 16'hFFFF);
      chk("w_next", imem_addr, 0);
      stall = 1'b1;
      @(negedge clk); chk("w_hold", imem_req, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_req", imem_req, 0);
      chk("ar_addr", imem_addr, 0);
      chk("ar_valid", inst_valid, 0);
      chk("ar_out", inst_out, 0);
      chk("ar_pc", inst_pc, 0);
`ifdef DSP_FETCH_PERF_EN
      chk("ar_cnt", stall_cnt, 0);
`endif
      @(negedge clk); rst_n = 1'b1; stall = 1'b0;
      // Mixed stall / latency / redirect pattern checked by the model
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         stall = (i % 5 == 3) || (i % 7 == 0) || (i % 40 >= 30 && i % 40 < 34);
         lat = (i / 25) % 3;
         redirect_valid = (i % 37 == 20) || (i % 53 == 10);
         redirect_addr = AW'(i * 7);
      end
      @(negedge clk);
      redirect_valid = 1'b0; stall = 1'b0; lat = 0;
`ifdef DSP_FETCH_PERF_EN
      n = 0;
      while (!inst_valid && n < 10) begin @(negedge clk); n++; end
      chk("p_valid", inst_valid, 1);
      stall = 1'b1;
      repeat (70000) @(negedge clk);
      chk("p_sat", stall_cnt, 16'hFFFF);
      stall = 1'b0;
`endif
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
